// File: rtl/wbc_pkg.sv
// rtl/wbc_pkg.sv - shared defaults, pointer width and entry type for wb_capture
// The entry layout depends on WBC_TIMESTAMP_EN.
package wbc_pkg;

    localparam int WBC_DW    = 16;
    localparam int WBC_DEPTH = 8;
    localparam int WBC_CW    = 8;
    localparam int WBC_TSW   = 16;
    localparam int PTRW      = $clog2(WBC_DEPTH);

    typedef struct packed {
`ifdef WBC_TIMESTAMP_EN
        logic [WBC_TSW-1:0] ts;
`endif
        logic [WBC_DW-1:0]  data;
    } wbc_entry_t;

endpackage

// File: rtl/wbc_mem.sv
// rtl/wbc_mem.sv - DEPTH x W register array, synchronous write, asynchronous read
// There is no reset, so the array maps onto plain flops or distributed RAM.
module wbc_mem #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_capture.sv
// rtl/wb_capture.sv - write-back capture FIFO with drop counting, FWFT drain port
// Optional head-entry timestamps when WBC_TIMESTAMP_EN is defined.
module wb_capture
    import wbc_pkg::*;
#(
    parameter int DW    = WBC_DW,
    parameter int DEPTH = WBC_DEPTH,
    parameter int CW    = WBC_CW,
    parameter int TSW   = WBC_TSW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_we,
    input  logic [DW-1:0]          in_wd,
    output logic                   out_valid,
    output logic [DW-1:0]          out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
`ifdef WBC_TIMESTAMP_EN
    output logic [TSW-1:0]         out_ts,
`endif
    output logic [CW-1:0]          drop_cnt
);

    localparam int PW = $clog2(DEPTH);
`ifdef WBC_TIMESTAMP_EN
    localparam int EW = DW + TSW;
`else
    localparam int EW = DW;
`endif

    logic [PW-1:0] rptr, wptr;
    logic [EW-1:0] wentry, rentry;
    logic          full, push, pop, drop;

    assign out_valid = (count != '0);
    assign full      = (count == (PW+1)'(DEPTH));
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = in_we & (~full | pop);
    assign drop      = in_we & full & ~pop;

`ifdef WBC_TIMESTAMP_EN
    logic [TSW-1:0] ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    assign wentry = {ts, in_wd};
    assign out_ts = rentry[EW-1:DW];
`else
    assign wentry = in_wd;
`endif

    assign out_data = rentry[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    wbc_mem #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~rst),
        .waddr (wptr),
        .wdata (wentry),
        .raddr (rptr),
        .rdata (rentry)
    );

endmodule

// File: doc/wb_capture.md
Name: wb_capture

Overview:
- Downstream consumer of the processing unit's write-back stream (we, wd).
- Captures every register-file write result into a small FIFO and presents it on a valid/ready drain port for a trace/output device.
- Lets the PU run at full rate with no back-pressure; results that arrive while the FIFO is full are counted and dropped.

Parameters:
DW, 16, write-back data width (matches PU wd width)
DEPTH, 8, FIFO entries; power of two, >= 2
CW, 8, drop-counter width
TSW, 16, timestamp width (used only with WBC_TIMESTAMP_EN)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
in_we  in  1  PU write enable; a capture request when high
in_wd  in  DW  PU write-back data
out_valid  out  1  head entry available
out_data  out  DW  head entry data
out_ready  in  1  sink accepts head entry this cycle
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
ovf  out  1  sticky: at least one capture dropped since reset
drop_cnt  out  CW  dropped captures, saturating at 2^CW-1

Behaviour:
- Reset (rst=1 at posedge, including mid-operation): rptr=wptr=0, count=0, out_valid=0, ovf=0, drop_cnt=0. Storage contents are don't-care. A push or pop in the reset cycle is ignored.
- Push: in_we=1 and (count<DEPTH or pop in the same cycle). Writes in_wd to mem[wptr] and increments wptr modulo DEPTH.
- Pop: out_valid=1 and out_ready=1. Increments rptr modulo DEPTH.
- First-word-fall-through:
  - out_valid = (count!=0).
  - out_data = mem[rptr], combinational from registered state.
  - out_data is don't-care when out_valid=0.
- Latency: a capture pushed at edge N is visible with out_valid=1 in cycle N+1. No same-cycle bypass when empty.
- Simultaneous push and pop:
  - Non-empty FIFO: both happen and count is unchanged.
  - Full FIFO: the push is accepted because the pop frees the slot; count stays DEPTH.
  - Empty FIFO: only the push happens (out_valid was 0); count becomes 1.
- Overflow (in_we=1, count==DEPTH, no pop):
  - The capture is dropped; FIFO contents are unchanged.
  - ovf is set to 1 and stays 1 until rst.
  - drop_cnt increments and saturates at all-ones.
- Pointer wrap-around: pointers use $clog2(DEPTH) bits and wrap naturally. count is tracked separately, so full and empty are unambiguous.
- out_ready while out_valid=0: no effect.
- Drain-side stability:
  - out_data must not change while out_valid=1 and out_ready=0.
  - out_valid must not drop without a pop or rst.
- count, ovf and drop_cnt are registered outputs.

Optional Feature:
- Macro WBC_TIMESTAMP_EN.
- Defined:
  - A free-running TSW-bit cycle counter is added: 0 after rst, +1 every cycle, wraps.
  - Each accepted push stores {ts, in_wd}, where ts is the counter value in the push cycle.
  - Extra output port out_ts [TSW-1:0] presents the timestamp of the head entry.
  - Dropped captures do not consume entries.
- Undefined: no counter, no out_ts port, entry width DW.

Decomposition:
- Shared header/package wbc_pkg:
  - DW, DEPTH, CW and TSW defaults.
  - Pointer-width constant PTRW=$clog2(DEPTH).
  - Entry type: DW data, plus TSW timestamp when WBC_TIMESTAMP_EN is defined.
- Sub-module wbc_mem:
  - DEPTH x entry register array.
  - Synchronous write port, asynchronous read port, no reset.
- Top module keeps pointers, count, flags and drop counter.

Test Plan:
- Reset, then push 0x0011,0x0022,0x0033 with out_ready=0 -> count=3, out_valid=1, out_data=0x0011; then out_ready=1 for 3 cycles -> pops 0x0011,0x0022,0x0033 in order, count=0, out_valid=0.
- 10 consecutive pushes 0x0100..0x0109, out_ready=0 -> count=8, ovf=1, drop_cnt=2; drain yields 0x0100..0x0107.
- Full FIFO, push 0xBEEF with out_ready=1 in the same cycle -> count stays 8, ovf stays 0, 0xBEEF emerges as 8th pop.
- Interleave 20 push/pop pairs with DEPTH=8 -> pointers wrap twice, output order equals input order, count never exceeds 1.
- Fill to 5 entries, assert rst for one cycle with in_we=1 -> next cycle count=0, out_valid=0, ovf=0, drop_cnt=0.
- WBC_TIMESTAMP_EN, reset, push 0x00AA at cycle 3 after reset -> out_ts=3, out_data=0x00AA.
